// File: rtl/relu_grad_gate.sv
`default_nettype none
// ============================================================================
// Module      : relu_grad_gate
// Description : Records a forward ReLU mask bit per activation in a FIFO and
//               gates the backward gradient stream with it, in FIFO order.
//               Define RELU_GRAD_LEAKY_EN for the leaky-ReLU backward slope.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_grad_gate #(
    parameter int ACT_WIDTH  = 20,
    parameter int GRAD_WIDTH = 20,
    parameter int MASK_DEPTH = 1024,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          fwd_valid,
    output logic                          fwd_ready,
    input  logic signed [ACT_WIDTH-1:0]   fwd_act,
    input  logic                          bwd_in_valid,
    output logic                          bwd_in_ready,
    input  logic signed [GRAD_WIDTH-1:0]  bwd_grad_in,
    output logic                          bwd_out_valid,
    input  logic                          bwd_out_ready,
    output logic signed [GRAD_WIDTH-1:0]  bwd_grad_out,
    output logic [$clog2(MASK_DEPTH):0]   mask_count
);

    localparam int                c_ptr_w   = $clog2(MASK_DEPTH);
    localparam int                c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(MASK_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

`ifndef RELU_GRAD_LEAKY_EN
    localparam int c_unused_leak_shift = LEAK_SHIFT;
`endif

    logic [c_ptr_w-1:0]           r_wr_ptr;
    logic [c_ptr_w-1:0]           r_rd_ptr;
    logic [c_cnt_w-1:0]           r_count;
    logic                         r_out_valid;
    logic signed [GRAD_WIDTH-1:0] r_grad_out;
    logic                         r_mask_mem [MASK_DEPTH];

    logic                         w_fwd_ready;
    logic                         w_bwd_in_ready;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_act_known;
    logic                         w_grad_known;
    logic                         w_mask_bit;
    logic                         w_pop_bit;
    logic signed [GRAD_WIDTH-1:0] w_gated;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign w_fwd_ready    = (r_count != c_full);
    assign w_bwd_in_ready = (r_count != '0) && (!r_out_valid || bwd_out_ready);
    assign w_push         = fwd_valid && w_fwd_ready && !clear;
    assign w_pop          = bwd_in_valid && w_bwd_in_ready && !clear;

    // Unknown bits on the data inputs force a zero mask / zero gradient.
    assign w_act_known  = ((^fwd_act) !== 1'bx);
    assign w_grad_known = ((^bwd_grad_in) !== 1'bx);
    assign w_mask_bit   = w_act_known && !fwd_act[ACT_WIDTH-1] && (|fwd_act);
    assign w_pop_bit    = r_mask_mem[r_rd_ptr];

    always_comb begin
        w_gated = '0;
        if (w_grad_known) begin
            if (w_pop_bit) begin
                w_gated = bwd_grad_in;
            end
`ifdef RELU_GRAD_LEAKY_EN
            else begin
                w_gated = bwd_grad_in >>> LEAK_SHIFT;
            end
`endif
        end
    end

    // Mask storage is intentionally unreset; only slots between the pointers are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mask_mem[r_wr_ptr] <= w_mask_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_grad_out  <= '0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_grad_out  <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_grad_out  <= w_gated;
        end else if (bwd_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign fwd_ready     = w_fwd_ready;
    assign bwd_in_ready  = w_bwd_in_ready;
    assign bwd_out_valid = r_out_valid;
    assign bwd_grad_out  = r_grad_out;
    assign mask_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_relu_grad_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_relu_grad_gate
// Description : Self-checking bench for relu_grad_gate: directed tables,
//               corner sequences and random traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_grad_gate;

    localparam int AW    = 20;
    localparam int GW    = 20;
    localparam int DEPTH = 16;
    localparam int LS    = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 clear;
    logic                 fwd_valid;
    logic                 fwd_ready;
    logic signed [AW-1:0] fwd_act;
    logic                 bwd_in_valid;
    logic                 bwd_in_ready;
    logic signed [GW-1:0] bwd_grad_in;
    logic                 bwd_out_valid;
    logic                 bwd_out_ready;
    logic signed [GW-1:0] bwd_grad_out;
    logic [CW-1:0]        mask_count;

    relu_grad_gate #(
        .ACT_WIDTH  (AW),
        .GRAD_WIDTH (GW),
        .MASK_DEPTH (DEPTH),
        .LEAK_SHIFT (LS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .fwd_valid     (fwd_valid),
        .fwd_ready     (fwd_ready),
        .fwd_act       (fwd_act),
        .bwd_in_valid  (bwd_in_valid),
        .bwd_in_ready  (bwd_in_ready),
        .bwd_grad_in   (bwd_grad_in),
        .bwd_out_valid (bwd_out_valid),
        .bwd_out_ready (bwd_out_ready),
        .bwd_grad_out  (bwd_grad_out),
        .mask_count    (mask_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of mask bits plus the single output slot.
    bit                   mq[$];
    bit                   m_valid;
    logic signed [GW-1:0] m_out;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic signed [GW-1:0] ref_gate(input bit m, input logic signed [GW-1:0] g);
        if ($isunknown(g)) return '0;
        if (m) return g;
`ifdef RELU_GRAD_LEAKY_EN
        return g >>> LS;
`else
        return '0;
`endif
    endfunction

    // One clock cycle: apply inputs, check handshakes, advance model, check registered outputs.
    task automatic cycle(input bit fv, input logic signed [AW-1:0] act, input bit iv,
                         input logic signed [GW-1:0] g, input bit ordy, input bit clr);
        bit e_frdy;
        bit e_irdy;
        bit b;
        fwd_valid     = fv;
        fwd_act       = act;
        bwd_in_valid  = iv;
        bwd_grad_in   = g;
        bwd_out_ready = ordy;
        clear         = clr;
        #1;
        e_frdy = (mq.size() != DEPTH);
        e_irdy = (mq.size() != 0) && (!m_valid || ordy);
        chk("fwd_ready", int'(fwd_ready), int'(e_frdy));
        chk("bwd_in_ready", int'(bwd_in_ready), int'(e_irdy));
        if (clr) begin
            mq.delete();
            m_valid = 1'b0;
            m_out   = '0;
        end else begin
            if (iv && e_irdy) begin
                b       = mq.pop_front();
                m_valid = 1'b1;
                m_out   = ref_gate(b, g);
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            if (fv && e_frdy) mq.push_back(!$isunknown(act) && (act > 0));
        end
        @(posedge clk);
        #1;
        chk("bwd_out_valid", int'(bwd_out_valid), int'(m_valid));
        if (m_valid) chk("bwd_grad_out", int'(bwd_grad_out), int'(m_out));
        chk("mask_count", int'(mask_count), mq.size());
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    typedef struct {
        bit                   fv;
        logic signed [AW-1:0] act;
        bit                   iv;
        logic signed [GW-1:0] g;
        bit                   e_valid;
        logic signed [GW-1:0] e_out;
        int                   e_count;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{1, 5,  0, 0,  0, 0,  1};
        vt[1] = '{1, -3, 0, 0,  0, 0,  2};
        vt[2] = '{1, 0,  0, 0,  0, 0,  3};
        vt[3] = '{1, 7,  0, 0,  0, 0,  4};
        vt[4] = '{0, 0,  1, 10, 1, 10, 3};
        vt[5] = '{0, 0,  1, 11, 1, 0,  2};
        vt[6] = '{0, 0,  1, 12, 1, 0,  1};
        vt[7] = '{0, 0,  1, 13, 1, 13, 0};
        vt[8] = '{0, 0,  0, 0,  0, 0,  0};

        rst_n = 1'b0; clear = 1'b0; fwd_valid = 1'b0; fwd_act = '0;
        bwd_in_valid = 1'b0; bwd_grad_in = '0; bwd_out_ready = 1'b1;
        m_valid = 1'b0; m_out = '0;
        #22;
        chk("reset fwd_ready", int'(fwd_ready), 1);
        chk("reset bwd_in_ready", int'(bwd_in_ready), 0);
        chk("reset bwd_out_valid", int'(bwd_out_valid), 0);
        chk("reset bwd_grad_out", int'(bwd_grad_out), 0);
        chk("reset mask_count", int'(mask_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic masking sequence against fixed expectations.
        foreach (vt[i]) begin
            cycle(vt[i].fv, vt[i].act, vt[i].iv, vt[i].g, 1'b1, 1'b0);
            chk("table valid", int'(bwd_out_valid), int'(vt[i].e_valid));
            if (vt[i].e_valid) chk("table out", int'(bwd_grad_out), int'(vt[i].e_out));
            chk("table count", int'(mask_count), vt[i].e_count);
        end

        // Fill to full, extra push refused, one pop re-opens.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, AW'(i + 1), 1'b0, '0, 1'b1, 1'b0);
        chk("full count", int'(mask_count), DEPTH);
        chk("full fwd_ready", int'(fwd_ready), 0);
        cycle(1'b1, -20'sd5, 1'b0, '0, 1'b1, 1'b0);
        chk("full no store", int'(mask_count), DEPTH);
        cycle(1'b0, '0, 1'b1, 20'sd99, 1'b1, 1'b0);
        chk("after pop fwd_ready", int'(fwd_ready), 1);
        chk("after pop out", int'(bwd_grad_out), 99);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        chk("clear count", int'(mask_count), 0);

        // Empty stall, then push with no same-cycle bypass.
        cycle(1'b0, '0, 1'b1, 20'sd33, 1'b1, 1'b0);
        chk("empty no valid", int'(bwd_out_valid), 0);
        cycle(1'b1, 20'sd1, 1'b1, 20'sd33, 1'b1, 1'b0);
        chk("no bypass", int'(bwd_out_valid), 0);
        cycle(1'b0, '0, 1'b1, 20'sd33, 1'b1, 1'b0);
        chk("stall release out", int'(bwd_grad_out), 33);

        // Output hold under backpressure.
        for (int i = 0; i < 3; i++) cycle(1'b1, 20'sd4, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, -20'sd8, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b1, 20'sd77, 1'b0, 1'b0);
            chk("hold out", int'(bwd_grad_out), -8);
            chk("hold count", int'(mask_count), 2);
        end
        cycle(1'b0, '0, 1'b1, 20'sd21, 1'b1, 1'b0);
        chk("resume out", int'(bwd_grad_out), 21);
        cycle(1'b0, '0, 1'b1, 20'sd22, 1'b1, 1'b0);
        chk("resume out2", int'(bwd_grad_out), 22);
        idle();

        // Clear with a pending output.
        for (int i = 0; i < 3; i++) cycle(1'b1, 20'sd2, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 20'sd6, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 20'sd6, 1'b0, 1'b1);
        chk("clear valid", int'(bwd_out_valid), 0);
        chk("clear count2", int'(mask_count), 0);

        // Leaky / default slope and unknown activation.
        cycle(1'b1, -20'sd1, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, -20'sd64, 1'b1, 1'b0);
`ifdef RELU_GRAD_LEAKY_EN
        chk("leak out", int'(bwd_grad_out), -8);
`else
        chk("leak out", int'(bwd_grad_out), 0);
`endif
        cycle(1'b1, 'x, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 20'sd512, 1'b1, 1'b0);
        chk("x act out", int'(bwd_grad_out), int'(ref_gate(1'b0, 20'sd512)));
        idle();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) cycle(1'b1, 20'sd3, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 20'sd40, 1'b0, 1'b0);
        fwd_valid = 1'b0; bwd_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete(); m_valid = 1'b0; m_out = '0;
        chk("async valid", int'(bwd_out_valid), 0);
        chk("async out", int'(bwd_grad_out), 0);
        chk("async count", int'(mask_count), 0);
        chk("async fwd_ready", int'(fwd_ready), 1);
        chk("async bwd_in_ready", int'(bwd_in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            logic signed [AW-1:0] a;
            case ($urandom_range(0, 3))
                0:       a = '0;
                1:       a = AW'($urandom_range(1, 100));
                2:       a = -AW'($urandom_range(1, 100));
                default: a = AW'($urandom);
            endcase
            cycle(($urandom_range(0, 99) < 55), a, ($urandom_range(0, 99) < 50),
                  GW'($urandom), ($urandom_range(0, 99) < 70), ($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
